// File: rtl/fpu_thread_arbiter.sv
// fpu_thread_arbiter
// Shares one multi-cycle FPU among THREADS_PER_BLOCK requesters. A round-robin
// grant picks one request at a time. The FPU is started with a single pulse and
// its result is routed back to the thread that issued the operation. A watchdog
// turns a hung FPU operation into an error response, so no thread can deadlock.

module fpu_thread_arbiter #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int OP_BITS           = 3,
  parameter int DATA_BITS         = 32,
  parameter int FLAG_BITS         = 5,
  parameter int TIMEOUT_CYCLES    = 64
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [THREADS_PER_BLOCK-1:0]           req_valid,
  input  logic [THREADS_PER_BLOCK*OP_BITS-1:0]   req_op,
  input  logic [THREADS_PER_BLOCK*DATA_BITS-1:0] req_a,
  input  logic [THREADS_PER_BLOCK*DATA_BITS-1:0] req_b,
  output logic [THREADS_PER_BLOCK-1:0]           req_ready,
  output logic [THREADS_PER_BLOCK-1:0]           rsp_valid,
  input  logic [THREADS_PER_BLOCK-1:0]           rsp_ready,
  output logic [DATA_BITS-1:0]                   rsp_result,
  output logic [FLAG_BITS-1:0]                   rsp_flags,
  output logic                                   rsp_timeout,
  output logic                                   fpu_start,
  output logic [OP_BITS-1:0]                     fpu_op,
  output logic [DATA_BITS-1:0]                   fpu_a,
  output logic [DATA_BITS-1:0]                   fpu_b,
  input  logic                                   fpu_done,
  input  logic [DATA_BITS-1:0]                   fpu_result,
  input  logic [FLAG_BITS-1:0]                   fpu_fflags,
  output logic                                   busy
);

  localparam int PTR_BITS   = (THREADS_PER_BLOCK > 1) ? $clog2(THREADS_PER_BLOCK) : 1;
  localparam int TIMER_BITS = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [PTR_BITS-1:0]   PTR_RESET    = PTR_BITS'(THREADS_PER_BLOCK - 1);
  localparam logic [TIMER_BITS-1:0] TIMER_LAST   = TIMER_BITS'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_BITS-1:0]  ABORT_RESULT = DATA_BITS'(32'h7FC0_0000);
  localparam logic [FLAG_BITS-1:0]  ABORT_FLAGS  = {1'b1, {(FLAG_BITS-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t state;
  state_t state_next;

  logic [PTR_BITS-1:0]   rr_ptr;
  logic [PTR_BITS-1:0]   tag;
  logic [TIMER_BITS-1:0] timer;
  logic                  rsp_timeout_q;

  logic                  grant_found;
  logic [PTR_BITS-1:0]   grant_idx;
  logic [PTR_BITS-1:0]   scan_idx;

  logic                  accept;
  logic                  timer_clear;
  logic                  timer_inc;
  logic                  load_done;
  logic                  load_abort;

  // Index base+step wrapped into the range 0..THREADS_PER_BLOCK-1; step never
  // exceeds THREADS_PER_BLOCK so one subtraction is enough.
  function automatic logic [PTR_BITS-1:0] wrap_add(input logic [PTR_BITS-1:0] base,
                                                   input int step);
    int sum;
    sum = int'(base) + step;
    if (sum >= THREADS_PER_BLOCK) begin
      sum = sum - THREADS_PER_BLOCK;
    end
    return PTR_BITS'(sum);
  endfunction

  // Round-robin search: first valid requester after the last winner, with wrap.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 1; k <= THREADS_PER_BLOCK; k++) begin
      scan_idx = wrap_add(rr_ptr, k);
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // State register; reset mid-operation drops the operation with no response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic plus the state-decoded outputs and datapath strobes.
  always_comb begin
    state_next  = state;
    req_ready   = '0;
    rsp_valid   = '0;
    rsp_timeout = 1'b0;
    fpu_start   = 1'b0;
    busy        = 1'b0;
    accept      = 1'b0;
    timer_clear = 1'b0;
    timer_inc   = 1'b0;
    load_done   = 1'b0;
    load_abort  = 1'b0;
    case (state)
      IDLE: begin
        if (grant_found && rst_n) begin
          req_ready[grant_idx] = 1'b1;
          accept               = 1'b1;
          state_next           = ISSUE;
        end
      end
      ISSUE: begin
        busy        = 1'b1;
        fpu_start   = 1'b1;
        timer_clear = 1'b1;
        state_next  = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (fpu_done) begin
          load_done  = 1'b1;
          state_next = RESP;
        end else if (timer == TIMER_LAST) begin
          load_abort = 1'b1;
          state_next = RESP;
        end else begin
          timer_inc = 1'b1;
        end
      end
      RESP: begin
        busy           = 1'b1;
        rsp_valid[tag] = 1'b1;
        rsp_timeout    = rsp_timeout_q;
        if (rsp_ready[tag]) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand capture on accept; operands then stay put until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpu_op <= '0;
      fpu_a  <= '0;
      fpu_b  <= '0;
      tag    <= '0;
      rr_ptr <= PTR_RESET;
    end else if (accept) begin
      fpu_op <= req_op[grant_idx*OP_BITS +: OP_BITS];
      fpu_a  <= req_a[grant_idx*DATA_BITS +: DATA_BITS];
      fpu_b  <= req_b[grant_idx*DATA_BITS +: DATA_BITS];
      tag    <= grant_idx;
      rr_ptr <= grant_idx;
    end
  end

  // Watchdog counter: restarted at issue, counts WAIT cycles without done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (timer_clear) begin
      timer <= '0;
    end else if (timer_inc) begin
      timer <= timer + TIMER_BITS'(1);
    end
  end

  // Response capture: a real completion beats the watchdog in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result    <= '0;
      rsp_flags     <= '0;
      rsp_timeout_q <= 1'b0;
    end else if (load_done) begin
      rsp_result    <= fpu_result;
      rsp_flags     <= fpu_fflags;
      rsp_timeout_q <= 1'b0;
    end else if (load_abort) begin
      rsp_result    <= ABORT_RESULT;
      rsp_flags     <= ABORT_FLAGS;
      rsp_timeout_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fpu_thread_arbiter.sv
// Testbench for fpu_thread_arbiter: directed scenarios with literal expectations
// plus a transaction-level model compared against the DUT every cycle.

module tb_fpu_thread_arbiter;

  localparam int N       = 4;
  localparam int OP_BITS = 3;
  localparam int DB      = 32;
  localparam int FB      = 5;
  localparam int TMO     = 64;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N*OP_BITS-1:0] req_op;
  logic [N*DB-1:0]   req_a;
  logic [N*DB-1:0]   req_b;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      rsp_valid;
  logic [N-1:0]      rsp_ready;
  logic [DB-1:0]     rsp_result;
  logic [FB-1:0]     rsp_flags;
  logic              rsp_timeout;
  logic              fpu_start;
  logic [OP_BITS-1:0] fpu_op;
  logic [DB-1:0]     fpu_a;
  logic [DB-1:0]     fpu_b;
  logic              fpu_done;
  logic [DB-1:0]     fpu_result;
  logic [FB-1:0]     fpu_fflags;
  logic              busy;

  int checks;
  int errors;

  int            stub_delay;
  int            stub_cnt;
  logic [DB-1:0] stub_result;
  logic [FB-1:0] stub_flags;

  fpu_thread_arbiter #(
    .THREADS_PER_BLOCK(N),
    .OP_BITS(OP_BITS),
    .DATA_BITS(DB),
    .FLAG_BITS(FB),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_op(req_op),
    .req_a(req_a),
    .req_b(req_b),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_result(rsp_result),
    .rsp_flags(rsp_flags),
    .rsp_timeout(rsp_timeout),
    .fpu_start(fpu_start),
    .fpu_op(fpu_op),
    .fpu_a(fpu_a),
    .fpu_b(fpu_b),
    .fpu_done(fpu_done),
    .fpu_result(fpu_result),
    .fpu_fflags(fpu_fflags),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction-level model: one operation in flight, described by its age
  // (cycles since it was accepted) and whether its response is being offered.
  bit            m_active;
  bit            m_resp;
  int            m_age;
  int            m_owner;
  int            m_last;
  logic [OP_BITS-1:0] m_op;
  logic [DB-1:0] m_a;
  logic [DB-1:0] m_b;
  logic [DB-1:0] m_res;
  logic [FB-1:0] m_flg;
  bit            m_to;
  int            model_pick;

  function automatic int pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  assign model_pick = pick(req_valid, m_last);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_resp   <= 1'b0;
      m_age    <= 0;
      m_owner  <= 0;
      m_last   <= N - 1;
      m_op     <= '0;
      m_a      <= '0;
      m_b      <= '0;
      m_res    <= '0;
      m_flg    <= '0;
      m_to     <= 1'b0;
    end else if (!m_active) begin
      if (model_pick >= 0) begin
        m_active <= 1'b1;
        m_age    <= 1;
        m_owner  <= model_pick;
        m_last   <= model_pick;
        m_op     <= req_op[model_pick*OP_BITS +: OP_BITS];
        m_a      <= req_a[model_pick*DB +: DB];
        m_b      <= req_b[model_pick*DB +: DB];
      end
    end else if (m_resp) begin
      if (rsp_ready[m_owner]) begin
        m_active <= 1'b0;
        m_resp   <= 1'b0;
      end
    end else if (m_age == 1) begin
      m_age <= 2;
    end else if (fpu_done) begin
      m_resp <= 1'b1;
      m_res  <= fpu_result;
      m_flg  <= fpu_fflags;
      m_to   <= 1'b0;
    end else if (m_age - 2 == TMO - 1) begin
      m_resp <= 1'b1;
      m_res  <= 32'h7FC0_0000;
      m_flg  <= 5'b10000;
      m_to   <= 1'b1;
    end else begin
      m_age <= m_age + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", name, actual, expected);
    end
  endtask

  logic [N-1:0] cmp_ready;
  logic [N-1:0] cmp_rsp;

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      cmp_ready = '0;
      if (!m_active && model_pick >= 0) cmp_ready[model_pick] = 1'b1;
      cmp_rsp = '0;
      if (m_resp) cmp_rsp[m_owner] = 1'b1;
      checkOutput("cmp_req_ready", 64'(req_ready), 64'(cmp_ready));
      checkOutput("cmp_rsp_valid", 64'(rsp_valid), 64'(cmp_rsp));
      checkOutput("cmp_busy", 64'(busy), 64'(m_active));
      checkOutput("cmp_fpu_start", 64'(fpu_start), 64'(m_active && !m_resp && m_age == 1));
      checkOutput("cmp_rsp_timeout", 64'(rsp_timeout), 64'(m_resp && m_to));
      if (m_active) begin
        checkOutput("cmp_fpu_op", 64'(fpu_op), 64'(m_op));
        checkOutput("cmp_fpu_a", 64'(fpu_a), 64'(m_a));
        checkOutput("cmp_fpu_b", 64'(fpu_b), 64'(m_b));
      end
      if (m_resp) begin
        checkOutput("cmp_rsp_result", 64'(rsp_result), 64'(m_res));
        checkOutput("cmp_rsp_flags", 64'(rsp_flags), 64'(m_flg));
      end
    end
  end

  // Advance one clock; inputs change 1 time unit after the edge. The FPU stub
  // raises done stub_delay cycles after the start pulse (0 = never).
  task automatic tick();
    @(posedge clk);
    #1;
    fpu_done = 1'b0;
    if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0) begin
        fpu_done   = 1'b1;
        fpu_result = stub_result;
        fpu_fflags = stub_flags;
      end
    end
    if (fpu_start && stub_delay > 0) stub_cnt = stub_delay;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic applyStimulus(input logic [N-1:0] valid, input logic [N-1:0] ready);
    req_valid = valid;
    rsp_ready = ready;
  endtask

  task automatic setThread(input int i, input logic [OP_BITS-1:0] op,
                           input logic [DB-1:0] a, input logic [DB-1:0] b);
    req_op[i*OP_BITS +: OP_BITS] = op;
    req_a[i*DB +: DB]            = a;
    req_b[i*DB +: DB]            = b;
  endtask

  task automatic waitIdle(input int budget);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < budget && !seen; t++) begin
      tick();
      settle();
      if (!busy) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL wait_idle got=busy expected=idle within %0d cycles", budget);
    end
  endtask

  task automatic waitRsp(input int budget);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < budget && !seen; t++) begin
      tick();
      settle();
      if (rsp_valid != '0) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL wait_rsp got=none expected=rsp_valid within %0d cycles", budget);
    end
  endtask

  function automatic int onehotIndex(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  int exp_order [5] = '{0, 1, 2, 3, 0};
  int got;

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    req_valid   = '0;
    req_op      = '0;
    req_a       = '0;
    req_b       = '0;
    rsp_ready   = '0;
    fpu_done    = 1'b0;
    fpu_result  = '0;
    fpu_fflags  = '0;
    stub_delay  = 0;
    stub_cnt    = 0;
    stub_result = '0;
    stub_flags  = '0;

    // Reset state, then a single request from thread 2 with D=3.
    $display("[TB] single request from thread 2");
    setThread(2, 3'd1, 32'h3F80_0000, 32'h4000_0000);
    applyStimulus(4'b0100, 4'b0000);
    tick();
    tick();
    settle();
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("rst_fpu_start", 64'(fpu_start), 64'd0);
    tick();
    rst_n       = 1'b1;
    stub_delay  = 3;
    stub_result = 32'h4040_0000;
    stub_flags  = 5'b00000;
    settle();
    checkOutput("t1_grant_c0", 64'(req_ready), 64'(4'b0100));
    tick();
    applyStimulus(4'b0000, 4'b0000);
    settle();
    checkOutput("t1_start_c1", 64'(fpu_start), 64'd1);
    checkOutput("t1_fpu_op", 64'(fpu_op), 64'd1);
    checkOutput("t1_fpu_a", 64'(fpu_a), 64'(32'h3F80_0000));
    checkOutput("t1_fpu_b", 64'(fpu_b), 64'(32'h4000_0000));
    tick();
    tick();
    tick();
    settle();
    checkOutput("t1_no_rsp_c4", 64'(rsp_valid), 64'd0);
    tick();
    settle();
    checkOutput("t1_rsp_valid_c5", 64'(rsp_valid), 64'(4'b0100));
    checkOutput("t1_rsp_result_c5", 64'(rsp_result), 64'(32'h4040_0000));
    checkOutput("t1_rsp_flags_c5", 64'(rsp_flags), 64'd0);
    applyStimulus(4'b0000, 4'b0100);
    tick();
    settle();
    checkOutput("t1_idle_busy", 64'(busy), 64'd0);
    checkOutput("t1_idle_rsp", 64'(rsp_valid), 64'd0);

    // All threads request continuously from reset: order must be 0,1,2,3,0.
    $display("[TB] round-robin with all threads requesting");
    tick();
    rst_n       = 1'b0;
    stub_cnt    = 0;
    stub_delay  = 1;
    stub_result = 32'h4120_0000;
    stub_flags  = 5'b00001;
    for (int i = 0; i < N; i++) begin
      setThread(i, 3'(i + 2), 32'h3F80_0000 + 32'(i), 32'h4000_0000 + 32'(i));
    end
    applyStimulus(4'b1111, 4'b1111);
    tick();
    rst_n = 1'b1;
    for (int op = 0; op < 5; op++) begin
      got = -1;
      for (int t = 0; t < 20 && got < 0; t++) begin
        settle();
        if (req_ready != '0) got = onehotIndex(req_ready);
        tick();
      end
      checkOutput("rr_grant_order", 64'(got), 64'(exp_order[op]));
    end
    applyStimulus(4'b0000, 4'b1111);
    waitIdle(20);

    // Response backpressure: held response, no new grant until thread 1 accepts.
    $display("[TB] response backpressure");
    tick();
    stub_delay  = 2;
    stub_result = 32'hC0A0_0000;
    stub_flags  = 5'b00001;
    setThread(1, 3'd3, 32'h1111_1111, 32'h2222_2222);
    setThread(3, 3'd4, 32'h3333_3333, 32'h4444_4444);
    applyStimulus(4'b0010, 4'b0000);
    settle();
    checkOutput("bp_grant", 64'(req_ready), 64'(4'b0010));
    tick();
    applyStimulus(4'b1000, 4'b1101);
    waitRsp(20);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin
        tick();
        settle();
      end
      checkOutput("bp_rsp_valid", 64'(rsp_valid), 64'(4'b0010));
      checkOutput("bp_rsp_result", 64'(rsp_result), 64'(32'hC0A0_0000));
      checkOutput("bp_req_ready", 64'(req_ready), 64'd0);
    end
    applyStimulus(4'b1000, 4'b0010);
    tick();
    settle();
    checkOutput("bp_regrant", 64'(req_ready), 64'(4'b1000));
    checkOutput("bp_rsp_dropped", 64'(rsp_valid), 64'd0);
    tick();
    applyStimulus(4'b0000, 4'b1111);
    waitIdle(20);

    // FPU never completes: watchdog abort after 64 WAIT cycles.
    $display("[TB] watchdog abort");
    tick();
    stub_delay = 0;
    setThread(2, 3'd6, 32'h5555_0000, 32'h0000_5555);
    applyStimulus(4'b0100, 4'b0000);
    settle();
    checkOutput("to_grant", 64'(req_ready), 64'(4'b0100));
    tick();
    applyStimulus(4'b0000, 4'b0000);
    for (int k = 2; k <= 65; k++) tick();
    settle();
    checkOutput("to_still_waiting", 64'(rsp_valid), 64'd0);
    checkOutput("to_busy", 64'(busy), 64'd1);
    tick();
    settle();
    checkOutput("to_rsp_valid", 64'(rsp_valid), 64'(4'b0100));
    checkOutput("to_rsp_result", 64'(rsp_result), 64'(32'h7FC0_0000));
    checkOutput("to_rsp_flags", 64'(rsp_flags), 64'(5'b10000));
    checkOutput("to_rsp_timeout", 64'(rsp_timeout), 64'd1);
    applyStimulus(4'b0000, 4'b0100);
    tick();
    settle();
    checkOutput("to_idle", 64'(busy), 64'd0);
    checkOutput("to_timeout_clear", 64'(rsp_timeout), 64'd0);

    // Spurious done in IDLE and ISSUE; real done in the final watchdog cycle.
    $display("[TB] spurious and late done");
    tick();
    fpu_done   = 1'b1;
    fpu_result = 32'hDEAD_BEEF;
    fpu_fflags = 5'b11111;
    settle();
    tick();
    setThread(1, 3'd2, 32'h0BAD_F00D, 32'hFEED_0001);
    applyStimulus(4'b0010, 4'b0000);
    fpu_done   = 1'b1;
    fpu_result = 32'hDEAD_BEEF;
    settle();
    checkOutput("sp_grant", 64'(req_ready), 64'(4'b0010));
    tick();
    fpu_done   = 1'b1;
    fpu_result = 32'hDEAD_BEEF;
    applyStimulus(4'b0000, 4'b0000);
    settle();
    checkOutput("sp_start", 64'(fpu_start), 64'd1);
    tick();
    settle();
    checkOutput("sp_ignored", 64'(rsp_valid), 64'd0);
    checkOutput("sp_busy", 64'(busy), 64'd1);
    for (int k = 3; k <= 65; k++) tick();
    fpu_done   = 1'b1;
    fpu_result = 32'h1234_5678;
    fpu_fflags = 5'b00001;
    settle();
    tick();
    settle();
    checkOutput("late_rsp_valid", 64'(rsp_valid), 64'(4'b0010));
    checkOutput("late_rsp_result", 64'(rsp_result), 64'(32'h1234_5678));
    checkOutput("late_rsp_flags", 64'(rsp_flags), 64'(5'b00001));
    checkOutput("late_rsp_timeout", 64'(rsp_timeout), 64'd0);
    applyStimulus(4'b0000, 4'b0010);
    tick();
    settle();
    checkOutput("late_idle", 64'(busy), 64'd0);

    // Reset in WAIT: outputs clear immediately, pointer returns to N-1.
    $display("[TB] reset during WAIT");
    tick();
    stub_delay = 0;
    setThread(2, 3'd5, 32'hAAAA_5555, 32'h5555_AAAA);
    applyStimulus(4'b0100, 4'b0000);
    settle();
    checkOutput("rw_grant", 64'(req_ready), 64'(4'b0100));
    tick();
    applyStimulus(4'b1111, 4'b0000);
    tick();
    tick();
    rst_n    = 1'b0;
    stub_cnt = 0;
    #1;
    checkOutput("rw_busy", 64'(busy), 64'd0);
    checkOutput("rw_fpu_start", 64'(fpu_start), 64'd0);
    checkOutput("rw_fpu_op", 64'(fpu_op), 64'd0);
    checkOutput("rw_fpu_a", 64'(fpu_a), 64'd0);
    checkOutput("rw_fpu_b", 64'(fpu_b), 64'd0);
    checkOutput("rw_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("rw_rsp_result", 64'(rsp_result), 64'd0);
    checkOutput("rw_rsp_flags", 64'(rsp_flags), 64'd0);
    checkOutput("rw_rsp_timeout", 64'(rsp_timeout), 64'd0);
    checkOutput("rw_req_ready", 64'(req_ready), 64'd0);
    tick();
    tick();
    rst_n       = 1'b1;
    stub_delay  = 2;
    stub_result = 32'h3F00_0000;
    stub_flags  = 5'b00000;
    rsp_ready   = 4'b1111;
    settle();
    checkOutput("rw_first_grant", 64'(req_ready), 64'(4'b0001));
    tick();
    applyStimulus(4'b0000, 4'b1111);
    waitIdle(20);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout got=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
